corr_dump_ctrl: RTL

Integrate-and-dump controller for the early/punctual/late correlator bank of `gps_receiver`. It gates and clears the six I/Q accumulators on code-epoch boundaries over a programmable number of 1 ms epochs. At each dump it captures the six results into a holding buffer and streams them to the tracking-loop processor over a valid/ready word interface. It sits between the code generator and correlator datapath on one side and the loop-filter/software interface on the other.

---
 rtl/gps_corr_pkg.sv | 29 ++
 rtl/corr_dump_ctrl_if.sv | 13 +
 rtl/corr_result_serializer.sv | 70 +++++++
 rtl/corr_dump_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gps_corr_pkg.sv
// Shared types and constants for the correlator integrate-and-dump controller.
// Word count follows CORR_DUMP_TIMESTAMP_EN (adds a dump-count word when defined).
package gps_corr_pkg;

   localparam int ACC_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_INTEG
   } corr_state_e;

   localparam logic [2:0] SEL_IE = 3'd0;
   localparam logic [2:0] SEL_QE = 3'd1;
   localparam logic [2:0] SEL_IP = 3'd2;
   localparam logic [2:0] SEL_QP = 3'd3;
   localparam logic [2:0] SEL_IL = 3'd4;
   localparam logic [2:0] SEL_QL = 3'd5;
   localparam logic [2:0] SEL_TS = 3'd6;

`ifdef CORR_DUMP_TIMESTAMP_EN
   localparam int N_WORDS = 7;
`else
   localparam int N_WORDS = 6;
`endif

   localparam logic [2:0] SEL_LAST = 3'(N_WORDS - 1);

endpackage

// File: rtl/corr_dump_ctrl_if.sv
// Result word stream from the dump controller to the tracking-loop processor.
interface corr_dump_ctrl_if #(parameter int ACC_W = 16);

   logic             valid;
   logic             ready;
   logic [ACC_W-1:0] data;
   logic [2:0]       sel;
   logic             last;

   modport master (output valid, data, sel, last, input ready);
   modport slave  (input valid, data, sel, last, output ready);

endinterface

// File: rtl/corr_result_serializer.sv
// Holding buffer for one dump plus the valid/ready word sequencer.
// busy means a load this cycle cannot be taken; a dropped dump sets the sticky overrun.
module corr_result_serializer
   import gps_corr_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         drop,
   input  logic [N_WORDS-1:0][ACC_W-1:0] load_words,
   input  logic                         overrun_clr,
   output logic                         busy,
   output logic                         overrun,
   corr_dump_ctrl_if.master             res
);

   logic [N_WORDS-1:0][ACC_W-1:0] hold_q;
   logic                          full_q;
   logic [2:0]                    sel_q;
   logic [ACC_W-1:0]              data_q;
   logic                          last_q;
   logic                          overrun_q;
   logic                          hs;
   logic                          last_hs;
   logic [2:0]                    nxt_sel;

   assign hs      = full_q & res.ready;
   assign last_hs = hs & last_q;
   assign nxt_sel = sel_q + 3'd1;
   // The final handshake frees the buffer in the same cycle a new dump may land.
   assign busy    = full_q & ~last_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= '0;
         full_q    <= 1'b0;
         sel_q     <= 3'd0;
         data_q    <= '0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load) begin
            hold_q <= load_words;
            full_q <= 1'b1;
            sel_q  <= 3'd0;
            data_q <= load_words[0];
            last_q <= 1'b0;
         end else if (last_hs) begin
            full_q <= 1'b0;
            sel_q  <= 3'd0;
            data_q <= '0;
            last_q <= 1'b0;
         end else if (hs) begin
            sel_q  <= nxt_sel;
            data_q <= hold_q[nxt_sel];
            last_q <= (nxt_sel == SEL_LAST);
         end
         overrun_q <= (overrun_q & ~overrun_clr) | drop;
      end
   end

   assign res.valid = full_q;
   assign res.sel   = sel_q;
   assign res.data  = data_q;
   assign res.last  = last_q;
   assign overrun   = overrun_q;

endmodule

// File: rtl/corr_dump_ctrl.sv
// Integrate-and-dump controller for the E/P/L correlator bank.
// Define CORR_DUMP_TIMESTAMP_EN to append the dump count as a seventh result word.
module corr_dump_ctrl
   import gps_corr_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEFAULT,
   parameter int INT_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    sample_valid,
   input  logic                    code_epoch,
   input  logic [INT_W-1:0]        int_ms,
   input  logic signed [ACC_W-1:0] acc_ie,
   input  logic signed [ACC_W-1:0] acc_qe,
   input  logic signed [ACC_W-1:0] acc_ip,
   input  logic signed [ACC_W-1:0] acc_qp,
   input  logic signed [ACC_W-1:0] acc_il,
   input  logic signed [ACC_W-1:0] acc_ql,
   output logic                    acc_en,
   output logic                    acc_clr,
   corr_dump_ctrl_if.master        res,
   output logic                    overrun,
   input  logic                    overrun_clr,
   output logic [15:0]             dump_cnt
);

   corr_state_e                   state_q, state_d;
   logic [INT_W-1:0]              ms_cnt_q;
   logic [INT_W-1:0]              int_len_q;
   logic [INT_W-1:0]              ms_inc;
   logic [INT_W-1:0]              int_ms_eff;
   logic [15:0]                   dump_cnt_q;
   logic                          epoch;
   logic                          start;
   logic                          dump;
   logic                          busy;
   logic [N_WORDS-1:0][ACC_W-1:0] words;

   assign epoch      = sample_valid & code_epoch;
   assign ms_inc     = ms_cnt_q + INT_W'(1);
   assign int_ms_eff = (int_ms == '0) ? INT_W'(1) : int_ms;

   always_comb begin
      state_d = state_q;
      acc_en  = 1'b0;
      acc_clr = 1'b0;
      start   = 1'b0;
      dump    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (epoch) begin
               acc_en  = 1'b1;
               acc_clr = 1'b1;
               start   = 1'b1;
               state_d = ST_INTEG;
            end
         end
         ST_INTEG: begin
            acc_en = sample_valid;
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (epoch && ms_inc == int_len_q) begin
               // Epoch sample starts the next integration, so no sample is lost.
               dump    = 1'b1;
               acc_clr = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ms_cnt_q   <= '0;
         int_len_q  <= INT_W'(1);
         dump_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (start || dump) begin
            ms_cnt_q  <= '0;
            int_len_q <= int_ms_eff;
         end else if (state_q == ST_INTEG && epoch) begin
            ms_cnt_q <= ms_inc;
         end
         if (dump) dump_cnt_q <= dump_cnt_q + 16'd1;
      end
   end

   always_comb begin
      words         = '0;
      words[SEL_IE] = acc_ie;
      words[SEL_QE] = acc_qe;
      words[SEL_IP] = acc_ip;
      words[SEL_QP] = acc_qp;
      words[SEL_IL] = acc_il;
      words[SEL_QL] = acc_ql;
`ifdef CORR_DUMP_TIMESTAMP_EN
      words[SEL_TS] = ACC_W'(dump_cnt_q + 16'd1);
`endif
   end

   corr_result_serializer #(.ACC_W(ACC_W)) u_ser (
      .clk         (clk),
      .rst         (rst),
      .load        (dump & ~busy),
      .drop        (dump & busy),
      .load_words  (words),
      .overrun_clr (overrun_clr),
      .busy        (busy),
      .overrun     (overrun),
      .res         (res)
   );

   assign dump_cnt = dump_cnt_q;

endmodule
